// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register file.
`timescale 1ns/1ps
package i2c_target_pkg;

  localparam int   BYTE_W = 8;
  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_ADDR       = 4'd1,
    ST_ADDR_ACK   = 4'd2,
    ST_REG        = 4'd3,
    ST_REG_ACK    = 4'd4,
    ST_WDATA      = 4'd5,
    ST_WDATA_ACK  = 4'd6,
    ST_RDATA      = 4'd7,
    ST_RDATA_MACK = 4'd8,
    ST_IGNORE     = 4'd9
  } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises raw SCL/SDA pins and derives SCL edges and START/STOP events.
`timescale 1ns/1ps
module i2c_bus_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;

  // Two-flop synchronisers plus one history flop; idle bus level is high.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= sda_sync_q;
    end
  end

  assign sda_o      = sda_sync_q;
  assign scl_rise_o = scl_sync_q & ~scl_hist_q;
  assign scl_fall_o = ~scl_sync_q & scl_hist_q;
  // SCL must be high on both samples so an SDA change near an SCL edge is not misread.
  assign start_o    = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
  assign stop_o     = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing a byte-wide register file with auto-incrementing pointer.
`timescale 1ns/1ps
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h2A,
  parameter int         NUM_REGS = 16,
  parameter int         PTR_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_read,
  input  logic              sda_read,
  output logic              sda_out,
  output logic              scl_out,
  input  logic [PTR_W-1:0]  host_addr,
  output logic [BYTE_W-1:0] host_data,
  output logic              wr_valid,
  output logic [PTR_W-1:0]  wr_addr,
  output logic [BYTE_W-1:0] wr_data,
  output logic              busy
);

  logic sda_s, scl_rise_s, scl_fall_s, start_s, stop_s, byte_done_s, reg_we_s;

  state_t              state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic                rw_q, rw_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                sda_q, sda_d;
  logic                busy_q, busy_d;
  logic                wr_valid_q, wr_valid_d;
  logic [PTR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]   wr_data_q, wr_data_d;
  logic [BYTE_W-1:0]   regs_q [NUM_REGS];
  logic [BYTE_W-1:0]   rd_byte_s;

  i2c_bus_sync u_sync (
    .clk_i      (clk),
    .reset_i    (reset),
    .scl_i      (scl_read),
    .sda_i      (sda_read),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise_s),
    .scl_fall_o (scl_fall_s),
    .start_o    (start_s),
    .stop_o     (stop_s)
  );

  // A byte is committed on the SCL fall after its 8th bit, so a START/STOP
  // landing during that last high phase still aborts the byte.
  assign byte_done_s = scl_fall_s && (bit_cnt_q == 4'd8);
  assign rd_byte_s   = regs_q[ptr_q];

  // Next-state logic for the protocol FSM, shifter, pointer and write strobe.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    ptr_d      = ptr_q;
    sda_d      = sda_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    reg_we_s   = 1'b0;
    if (start_s) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_d     = 1'b1;
    end else if (stop_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_d     = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (scl_rise_s) begin
            shift_d   = {shift_q[BYTE_W-2:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_done_s) begin
            bit_cnt_d = 4'd0;
            sda_d     = ACK;
            case (state_q)
              ST_ADDR: begin
                if (shift_q[BYTE_W-1:1] == DEV_ADDR) begin
                  rw_d    = shift_q[0];
                  state_d = ST_ADDR_ACK;
                end else begin
                  sda_d   = NACK;
                  state_d = ST_IGNORE;
                end
              end
              ST_REG: begin
                ptr_d   = shift_q[PTR_W-1:0];
                state_d = ST_REG_ACK;
              end
              default: begin
                reg_we_s   = 1'b1;
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = shift_q;
                ptr_d      = ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
                state_d    = ST_WDATA_ACK;
              end
            endcase
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall_s) begin
            sda_d     = 1'b1;
            bit_cnt_d = 4'd0;
            if ((state_q == ST_ADDR_ACK) && rw_q) begin
              state_d = ST_RDATA;
              shift_d = rd_byte_s;
              sda_d   = rd_byte_s[BYTE_W-1];
            end else if (state_q == ST_ADDR_ACK) begin
              state_d = ST_REG;
            end else begin
              state_d = ST_WDATA;
            end
          end else begin
            sda_d = sda_q;
          end
        end
        ST_RDATA: begin
          if (scl_rise_s) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_done_s) begin
            sda_d     = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = ST_RDATA_MACK;
          end else if (scl_fall_s) begin
            shift_d = {shift_q[BYTE_W-2:0], 1'b0};
            sda_d   = shift_q[BYTE_W-2];
          end else begin
            sda_d = sda_q;
          end
        end
        ST_RDATA_MACK: begin
          if (scl_rise_s) begin
            ptr_d = ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            if (sda_s == NACK) begin
              state_d = ST_IGNORE;
            end else begin
              state_d = ST_RDATA_MACK;
            end
          end else if (scl_fall_s) begin
            state_d   = ST_RDATA;
            bit_cnt_d = 4'd0;
            shift_d   = rd_byte_s;
            sda_d     = rd_byte_s[BYTE_W-1];
          end else begin
            sda_d = sda_q;
          end
        end
        ST_IDLE, ST_IGNORE: begin
          sda_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          sda_d   = 1'b1;
        end
      endcase
    end
  end

  // busy rises once the address is accepted and holds across a repeated START;
  // a non-matching address therefore never raises it.
  always_comb begin
    case (state_d)
      ST_IDLE, ST_IGNORE: busy_d = 1'b0;
      ST_ADDR:            busy_d = busy_q;
      default:            busy_d = 1'b1;
    endcase
  end

  // Protocol state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      ptr_q      <= '0;
      sda_q      <= 1'b1;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      ptr_q      <= ptr_d;
      sda_q      <= sda_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Register file, written with the completed byte at the current pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (reg_we_s) begin
      regs_q[ptr_q] <= shift_q;
    end
  end

  assign sda_out   = sda_q;
  assign scl_out   = 1'b1;
  assign host_data = regs_q[host_addr];
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;

endmodule
